spi_master_gen: RTL
===================

Name: spi_master_gen

Overview:
- Parametrised, mode-configurable SPI master. It succeeds the fixed-function controller used for the W25Q16 flash, the MPU6000 and the 74HC595 chain.
- Moves one DATA_W-bit word per transaction, MSB first, over a valid/ready command interface.
- Supports run-time CPOL/CPHA selection, a programmable SCLK divider, NUM_SS one-hot active-low selects, and chip-select hold for multi-word bursts (flash command + address + data).
- Sits between the system controller/sequencer and the board SPI pins.

Parameters:
- DATA_W, 8: bits per transaction word.
- NUM_SS, 4: number of slave-select lines.
- DIV_W, 8: width of the SCLK divider input.
- SS_W, max(1,$clog2(NUM_SS)): width of the slave index (derived, not overridable).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous active-high reset.
- tx_valid_i  in  1  command valid.
- tx_ready_o  out  1  master can accept a command.
- tx_data_i  in  DATA_W  word to shift out.
- ss_sel_i  in  SS_W  target slave index.
- cpol_i  in  1  SCLK idle level.
- cpha_i  in  1  0 = sample on leading edge, 1 = sample on trailing edge.
- clk_div_i  in  DIV_W  half-period = clk_div_i+1 clk cycles.
- hold_ss_i  in  1  keep SS asserted after this word.
- cs_release_i  in  1  deassert a held SS.
- rx_valid_o  out  1  one-cycle pulse, rx_data_o valid.
- rx_data_o  out  DATA_W  word captured from MISO.
- busy_o  out  1  high in any state except IDLE.
- SCLK_o  out  1  serial clock.
- MOSI_o  out  1  serial data out.
- MISO_i  in  1  serial data in.
- SS_o  out  NUM_SS  slave selects, active-low, at most one low.

Behaviour:
- Clock/reset: single clock clk_i; rst_i is asynchronous, active-high.
- Reset values, applied immediately, also mid-transaction (no completion, no rx_valid_o): SCLK_o=0, MOSI_o=0, SS_o=all ones, rx_valid_o=0, rx_data_o=0, busy_o=0, state=IDLE, latched cpol=0.
- Accept: the handshake fires on a cycle where tx_valid_i and tx_ready_o are both high.
- Latching at accept: tx_data_i, ss_sel_i, cpol_i, cpha_i, clk_div_i and hold_ss_i are latched. Later input changes have no effect until the next accept.
- SCLK idle level: SCLK_o takes the new cpol on the cycle after accept.
- tx_ready_o: high in IDLE; high in CS_HOLD when cs_release_i=0; low otherwise.
- Half-period counter: reloads with clk_div_i. One half-period elapses when it reaches 0 (clk_div_i+1 cycles).
- States:
  - IDLE: SS_o all ones, SCLK_o=cpol. On accept go to SETUP.
  - SETUP: SS_o[sel] low, MOSI_o = bit DATA_W-1 when cpha=0. Lasts one half-period, then go to SHIFT.
  - SHIFT: 2*DATA_W SCLK edges, one per half-period, alternating leading and trailing.
    - cpha=0: sample MISO on leading edges; drive the next MOSI bit on trailing edges.
    - cpha=1: drive MOSI on leading edges (first drive = MSB); sample on trailing edges.
    - After the last edge go to HOLD.
  - HOLD: SCLK_o=cpol, SS_o still asserted, one half-period. Then rx_data_o is updated and rx_valid_o pulses for 1 cycle. Next state is CS_HOLD if latched hold=1, otherwise GAP.
  - CS_HOLD: SS_o stays asserted, SCLK_o=cpol.
    - cs_release_i=1 goes to GAP and has priority (tx_ready_o low that cycle).
    - Accept with the same ss_sel goes to SETUP with SS kept low.
    - Accept with a different ss_sel goes to GAP, then SETUP. The accepted command is held and executed.
  - GAP: SS_o all ones for one half-period (guaranteed CS-high time). Then go to SETUP if a command is pending, else IDLE.
- Out-of-range ss_sel (>= NUM_SS): no SS line asserted; the transaction still runs and completes normally.
- Timing: SS low duration for one non-held word = (2*DATA_W+2)*(clk_div_i+1) cycles.
- Edge-count arithmetic: the bit counter is $clog2(2*DATA_W)+1 bits wide and never wraps.

Test Plan:
1. Mode 0, DATA_W=8, clk_div=0, tx 0xA5 to slave 2, MISO tied to MOSI -> SS_o=4'b1011 for 18 cycles, 8 SCLK rising edges, rx_data_o=0xA5, single rx_valid_o pulse, busy_o falls after GAP.
2. Mode 3 (cpol=1, cpha=1), clk_div=3, tx 0x3C, slave model returns 0xC3 -> SCLK idles high, half-period 4 cycles, SS low 72 cycles, rx_data_o=0xC3.
3. Burst of 4 words (0x0B, 0x00, 0x10, 0x00) with hold_ss_i=1, then cs_release_i -> SS_o[0] stays low across all words, 4 rx_valid_o pulses, SS rises only after release plus one half-period GAP.
4. In CS_HOLD on slave 0, accept a command with ss_sel=1 -> SS_o[0] rises, a GAP of clk_div+1 cycles shows all ones, then SS_o[1] falls and the word shifts.
5. rst_i asserted mid-SHIFT (after bit 3) -> SCLK_o=0, SS_o all ones and MOSI_o=0 asynchronously, no rx_valid_o; the next command after reset completes correctly.
6. cs_release_i and tx_valid_i high in the same CS_HOLD cycle -> tx_ready_o=0, command not accepted, GAP entered; the command is accepted later in IDLE.

Source files
------------

// File: rtl/spi_master_gen_if.sv
// Command, response and SPI pin bundle for spi_master_gen.
// The master modport is the SPI master itself; the slave modport is the controller/board side.
interface spi_master_gen_if #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
);
  localparam int SS_W = ($clog2(NUM_SS) > 1) ? $clog2(NUM_SS) : 1;

  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] tx_data_i;
  logic [SS_W-1:0]   ss_sel_i;
  logic              cpol_i;
  logic              cpha_i;
  logic [DIV_W-1:0]  clk_div_i;
  logic              hold_ss_i;
  logic              cs_release_i;
  logic              rx_valid_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              busy_o;
  logic              SCLK_o;
  logic              MOSI_o;
  logic              MISO_i;
  logic [NUM_SS-1:0] SS_o;

  modport master (
    input  tx_valid_i, tx_data_i, ss_sel_i, cpol_i, cpha_i, clk_div_i,
           hold_ss_i, cs_release_i, MISO_i,
    output tx_ready_o, rx_valid_o, rx_data_o, busy_o, SCLK_o, MOSI_o, SS_o
  );

  modport slave (
    output tx_valid_i, tx_data_i, ss_sel_i, cpol_i, cpha_i, clk_div_i,
           hold_ss_i, cs_release_i, MISO_i,
    input  tx_ready_o, rx_valid_o, rx_data_o, busy_o, SCLK_o, MOSI_o, SS_o
  );
endinterface

// File: rtl/spi_master_gen.sv
// Mode-configurable SPI master: one DATA_W word per command, MSB first, SS held across bursts.
// SS low for (2*DATA_W+2) half-periods per word; tx_ready only in IDLE or CS_HOLD without release.
module spi_master_gen #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int DIV_W  = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  spi_master_gen_if.master bus
);
  localparam int SS_W  = ($clog2(NUM_SS) > 1) ? $clog2(NUM_SS) : 1;
  localparam int CNT_W = $clog2(2 * DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, CS_HOLD, GAP} state_t;

  state_t            state;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [SS_W-1:0]   sel_q;
  logic              cpol_q;
  logic              cpha_q;
  logic [DIV_W-1:0]  div_q;
  logic              hold_q;
  logic              pending;
  logic [DIV_W-1:0]  half_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sclk;
  logic              mosi;
  logic [NUM_SS-1:0] ss;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;

  logic tx_ready;
  logic accept;
  logic half_done;
  logic drive_edge;

  // Out-of-range indices match no line, so the word still runs with every select high.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SS_W-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (SS_W'(i) == sel) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign tx_ready   = (state == IDLE) || ((state == CS_HOLD) && !bus.cs_release_i);
  assign accept     = bus.tx_valid_i && tx_ready;
  assign half_done  = (half_cnt == '0);
  // Even edge counts are leading edges; cpha picks whether those drive or sample.
  assign drive_edge = cpha_q ? ~edge_cnt[0] : edge_cnt[0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sel_q    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      hold_q   <= 1'b0;
      pending  <= 1'b0;
      half_cnt <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      ss       <= '1;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      if (!half_done && (state == SETUP || state == SHIFT || state == HOLD || state == GAP))
        half_cnt <= half_cnt - DIV_W'(1);

      case (state)
        IDLE: begin
          if (accept) begin
            ss    <= ss_decode(bus.ss_sel_i);
            state <= SETUP;
            if (!bus.cpha_i) mosi <= bus.tx_data_i[DATA_W-1];
          end
        end
        SETUP: begin
          if (half_done) begin
            half_cnt <= div_q;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_done) begin
            half_cnt <= div_q;
            sclk     <= ~sclk;
            edge_cnt <= edge_cnt + CNT_W'(1);
            if (drive_edge) begin
              // With cpha=0 the MSB already went out in SETUP, so trailing edges drive the next bit.
              mosi  <= cpha_q ? tx_sr[DATA_W-1] : tx_sr[DATA_W-2];
              tx_sr <= tx_sr << 1;
            end else begin
              rx_sr <= {rx_sr[DATA_W-2:0], bus.MISO_i};
            end
            if (edge_cnt == LAST_EDGE) state <= HOLD;
          end
        end
        HOLD: begin
          if (half_done) begin
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            if (hold_q) begin
              state <= CS_HOLD;
            end else begin
              state    <= GAP;
              ss       <= '1;
              half_cnt <= div_q;
            end
          end
        end
        CS_HOLD: begin
          if (bus.cs_release_i) begin
            state    <= GAP;
            ss       <= '1;
            half_cnt <= div_q;
          end else if (accept) begin
            if (bus.ss_sel_i == sel_q) begin
              state <= SETUP;
              if (!bus.cpha_i) mosi <= bus.tx_data_i[DATA_W-1];
            end else begin
              state   <= GAP;
              ss      <= '1;
              pending <= 1'b1;
            end
          end
        end
        GAP: begin
          if (half_done) begin
            if (pending) begin
              pending  <= 1'b0;
              state    <= SETUP;
              ss       <= ss_decode(sel_q);
              half_cnt <= div_q;
              if (!cpha_q) mosi <= tx_sr[DATA_W-1];
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Command capture overrides the per-state counter updates above.
      if (accept) begin
        tx_sr    <= bus.tx_data_i;
        sel_q    <= bus.ss_sel_i;
        cpol_q   <= bus.cpol_i;
        cpha_q   <= bus.cpha_i;
        div_q    <= bus.clk_div_i;
        hold_q   <= bus.hold_ss_i;
        sclk     <= bus.cpol_i;
        half_cnt <= bus.clk_div_i;
        edge_cnt <= '0;
      end
    end
  end

  assign bus.tx_ready_o = tx_ready;
  assign bus.rx_valid_o = rx_valid;
  assign bus.rx_data_o  = rx_data;
  assign bus.busy_o     = (state != IDLE);
  assign bus.SCLK_o     = sclk;
  assign bus.MOSI_o     = mosi;
  assign bus.SS_o       = ss;
endmodule
